// File: rtl/binary_mul_pkg.sv
// rtl/binary_mul_pkg.sv - shared types and helpers for the multiplier/accumulator datapath
package binary_mul_pkg;

    localparam int PROD_W = 11;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // A 6x6 signed multiplier never yields -1024, so that code carries +1024 (-32 * -32).
    function automatic logic signed [PROD_W:0] prod_value(input logic [PROD_W-1:0] p);
        logic sign;
        sign = p[PROD_W-1] & (|p[PROD_W-2:0]);
        return {sign, p};
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/binary_acc_add.sv
// rtl/binary_acc_add.sv - accumulator adder; clamps and flags overflow under BINARY_MAC_ACC_SAT_EN
module binary_acc_add
    import binary_mul_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
`ifdef BINARY_MAC_ACC_SAT_EN
    output logic              ovf,
`endif
    output logic [ACC_W-1:0]  sum
);

`ifdef BINARY_MAC_ACC_SAT_EN
    localparam int              FULL_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

    logic signed [ACC_W:0] w_full;

    // One guard bit: sum overflowed iff the two top bits disagree.
    assign w_full = $signed({acc[ACC_W-1], acc}) + FULL_W'(prod_value(prod));
    assign ovf    = w_full[ACC_W] ^ w_full[ACC_W-1];
    assign sum    = !ovf ? w_full[ACC_W-1:0] : (w_full[ACC_W] ? MIN_V : MAX_V);
`else
    assign sum = acc + ACC_W'(prod_value(prod));
`endif

endmodule

// File: rtl/binary_mac_acc.sv
// rtl/binary_mac_acc.sv - frame accumulator after the 6x6 multiplier; saturation via BINARY_MAC_ACC_SAT_EN
module binary_mac_acc
    import binary_mul_pkg::*;
#(
    parameter int LEN   = 8,
    parameter int ACC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int               CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_sum;
    logic [ACC_W-1:0] w_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             w_beat;
    logic             w_last;

    assign w_beat = in_valid && (r_state == ACC) && !clr;
    assign w_last = (r_cnt == LAST);

`ifdef BINARY_MAC_ACC_SAT_EN
    logic w_ovf;
    logic r_ovf;
    logic r_out_ovf;

    binary_acc_add #(.ACC_W(ACC_W)) u_add (
        .acc  (r_acc),
        .prod (in_prod),
        .ovf  (w_ovf),
        .sum  (w_sum)
    );

    // r_ovf is sticky across the frame; r_out_ovf is captured with the total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf     <= 1'b0;
            r_out_ovf <= 1'b0;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            if (w_last) begin
                r_out_ovf <= r_ovf | w_ovf;
                r_ovf     <= 1'b0;
            end else begin
                r_ovf <= r_ovf | w_ovf;
            end
        end
    end

    assign out_ovf = r_out_ovf;
`else
    binary_acc_add #(.ACC_W(ACC_W)) u_add (
        .acc  (r_acc),
        .prod (in_prod),
        .sum  (w_sum)
    );

    assign out_ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ACC;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACC:     if (w_beat && w_last) w_state_nxt = HOLD;
            HOLD:    if (clr || out_ready) w_state_nxt = ACC;
            default: w_state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_sum <= '0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_beat) begin
            if (w_last) begin
                r_sum <= w_sum;
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == HOLD);
    assign out_sum   = r_sum;

endmodule

// File: tb/tb_binary_mac_acc.sv
// tb/tb_binary_mac_acc.sv - randomized self-checking bench for binary_mac_acc (LEN=8/ACC_W=16 and LEN=4/ACC_W=12)
module tb_binary_mac_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr [2];
    logic        in_valid [2];
    logic        out_ready [2];
    logic [10:0] in_prod [2];
    logic        in_ready [2];
    logic        out_valid [2];
    logic        out_ovf [2];
    logic [15:0] sum0;
    logic [11:0] sum1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    binary_mac_acc #(.LEN(8), .ACC_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_prod(in_prod[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum0), .out_ovf(out_ovf[0])
    );

    binary_mac_acc #(.LEN(4), .ACC_W(12)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_prod(in_prod[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum1), .out_ovf(out_ovf[1])
    );

    function automatic longint got_sum(input int d);
        return (d == 0) ? longint'($signed(sum0)) : longint'($signed(sum1));
    endfunction

    function automatic int frame_len(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    // Product of two random 6-bit signed operands, as the upstream multiplier delivers.
    function automatic int rand_prod();
        int a;
        int b;
        a = int'($urandom_range(0, 63)) - 32;
        b = int'($urandom_range(0, 63)) - 32;
        return a * b;
    endfunction

    // Reference: integer running sum, clamped each step or wrapped at the end.
    function automatic void model(input int d, input int prods[$], output longint s, output bit o);
        int     w;
        longint hi;
        longint lo;
        longint a;
        w  = (d == 0) ? 16 : 12;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        a  = 0;
        o  = 1'b0;
        foreach (prods[i]) begin
            a += prods[i];
`ifdef BINARY_MAC_ACC_SAT_EN
            if (a > hi) begin a = hi; o = 1'b1; end
            else if (a < lo) begin a = lo; o = 1'b1; end
`endif
        end
`ifndef BINARY_MAC_ACC_SAT_EN
        a = a & ((longint'(1) <<< w) - 1);
        if (a > hi) a -= (longint'(1) <<< w);
`endif
        s = a;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_beat(input int d, input int p);
        int guard;
        guard       = 0;
        in_valid[d] = 1'b1;
        in_prod[d]  = 11'(p);
        while (!in_ready[d] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_timeout dut%0d in_ready stuck at %0b, want 1", d, in_ready[d]);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_prod[d]  = 11'($urandom);
    endtask

    task automatic run_frame(input int d, input int prods[$], input int gap_max, input int stall, input string tag);
        longint exp_sum;
        bit     exp_ovf;
        model(d, prods, exp_sum, exp_ovf);
        out_ready[d] = (stall == 0);
        foreach (prods[i]) begin
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            send_beat(d, prods[i]);
        end
        vectors++;
        if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_hold_entry dut%0d out_valid=%0b in_ready=%0b, want 1 0", tag, d, out_valid[d], in_ready[d]);
        end
        vectors++;
        if (got_sum(d) !== exp_sum) begin
            miscompares++;
            $display("FAIL %s_sum dut%0d got %0d want %0d", tag, d, got_sum(d), exp_sum);
        end
        vectors++;
        if (out_ovf[d] !== exp_ovf) begin
            miscompares++;
            $display("FAIL %s_ovf dut%0d got %0b want %0b", tag, d, out_ovf[d], exp_ovf);
        end
        for (int k = 0; k < stall; k++) begin
            in_valid[d] = 1'b1;
            in_prod[d]  = 11'(rand_prod());
            @(negedge clk);
            vectors++;
            if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || got_sum(d) !== exp_sum) begin
                miscompares++;
                $display("FAIL %s_stall dut%0d cyc %0d valid=%0b ready=%0b sum=%0d, want 1 0 %0d",
                         tag, d, k, out_valid[d], in_ready[d], got_sum(d), exp_sum);
            end
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_release dut%0d out_valid=%0b in_ready=%0b, want 0 1", tag, d, out_valid[d], in_ready[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            clr[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b1; in_prod[d] = '0;
        end
        idle(2);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || got_sum(d) !== 0 || out_ovf[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset dut%0d valid=%0b ready=%0b sum=%0d ovf=%0b, want 0 1 0 0",
                         d, out_valid[d], in_ready[d], got_sum(d), out_ovf[d]);
            end
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        int q[$];
        q = {};
        repeat (8) q.push_back(3);
        run_frame(0, q, 0, 0, "basic");
        vectors++;
        if (got_sum(0) !== 24) begin
            miscompares++;
            $display("FAIL basic_const got %0d want 24", got_sum(0));
        end
    endtask

    task automatic test_mixed();
        int q[$];
        q = {-992, 1024, -32, 5};
        run_frame(1, q, 0, 0, "mixed");
        vectors++;
        if (got_sum(1) !== 5) begin
            miscompares++;
            $display("FAIL mixed_const got %0d want 5", got_sum(1));
        end
    endtask

    task automatic test_hold();
        int q[$];
        q = {};
        repeat (8) q.push_back(rand_prod());
        run_frame(0, q, 0, 10, "hold");
        q = {};
        repeat (8) q.push_back(rand_prod());
        run_frame(0, q, 1, 0, "after_hold");
    endtask

    task automatic test_clr();
        int q[$];
        repeat (3) send_beat(0, rand_prod());
        in_valid[0] = 1'b1;
        in_prod[0]  = 11'd100;
        clr[0]      = 1'b1;
        @(negedge clk);
        clr[0]      = 1'b0;
        in_valid[0] = 1'b0;
        q = {};
        repeat (8) q.push_back(1);
        run_frame(0, q, 0, 0, "clr_acc");
        vectors++;
        if (got_sum(0) !== 8) begin
            miscompares++;
            $display("FAIL clr_const got %0d want 8", got_sum(0));
        end
        out_ready[1] = 1'b0;
        repeat (4) send_beat(1, rand_prod());
        clr[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        vectors++;
        if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_hold valid=%0b ready=%0b, want 0 1", out_valid[1], in_ready[1]);
        end
        q = {};
        repeat (4) q.push_back(rand_prod());
        run_frame(1, q, 0, 0, "after_clr");
    endtask

    task automatic test_overflow();
        int q[$];
        q = {1024, 1024, 1024, 1024};
        run_frame(1, q, 0, 0, "ovf");
        vectors++;
`ifdef BINARY_MAC_ACC_SAT_EN
        if (got_sum(1) !== 2047 || out_ovf[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_const sum=%0d ovf=%0b, want 2047 1", got_sum(1), out_ovf[1]);
        end
`else
        if (got_sum(1) !== 0 || out_ovf[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_const sum=%0d ovf=%0b, want 0 0", got_sum(1), out_ovf[1]);
        end
`endif
        q = {1024, 1024, -1024 + 32, -900};
        run_frame(1, q, 0, 0, "ovf_sticky");
        q = {5, -7, 9, 1};
        run_frame(1, q, 0, 0, "ovf_cleared");
    endtask

    task automatic test_random();
        int q[$];
        int d;
        for (int it = 0; it < 16; it++) begin
            d = int'($urandom_range(0, 1));
            q = {};
            repeat (frame_len(d)) q.push_back(rand_prod());
            run_frame(d, q, 2, int'($urandom_range(0, 3)), "rand");
        end
    endtask

    task automatic test_async_rst();
        int q[$];
        out_ready[0] = 1'b0;
        repeat (8) send_beat(0, 5);
        repeat (2) send_beat(1, 700);
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || got_sum(d) !== 0 || out_ovf[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL async_rst dut%0d valid=%0b ready=%0b sum=%0d ovf=%0b, want 0 1 0 0",
                         d, out_valid[d], in_ready[d], got_sum(d), out_ovf[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready[0] = 1'b1;
        q = {};
        repeat (4) q.push_back(rand_prod());
        run_frame(1, q, 0, 0, "post_rst1");
        q = {};
        repeat (8) q.push_back(rand_prod());
        run_frame(0, q, 0, 0, "post_rst0");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mixed();
        test_hold();
        test_clr();
        test_overflow();
        test_random();
        test_async_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
